alu_nzcv: RTL and testbench

Datapath ALU for the single-cycle ARM-style core. Computes ADD/SUB/AND/ORR on two operands combinationally and produces NZCV condition flags. A registered flag bank (CPSR-style) captures the flags under a two-bit write enable, for use by conditional execution.

---
 rtl/alu_nzcv_if.sv | 33 +++
 rtl/alu_nzcv.sv | 104 ++++++++++
 tb/tb_alu_nzcv.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_nzcv_if.sv
// Operand, control and result bundle between the core datapath and the NZCV ALU.
// The master drives operands and controls; the slave (ALU) drives results and flags.
interface alu_nzcv_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       ALUControl;
   logic [1:0]       FlagW;
   logic [WIDTH-1:0] Result;
   logic [3:0]       ALUFlags;
   logic [3:0]       Flags;

   modport master (
      output a,
      output b,
      output ALUControl,
      output FlagW,
      input  Result,
      input  ALUFlags,
      input  Flags
   );

   modport slave (
      input  a,
      input  b,
      input  ALUControl,
      input  FlagW,
      output Result,
      output ALUFlags,
      output Flags
   );
endinterface

// File: rtl/alu_nzcv.sv
// ADD/SUB/AND/ORR ALU producing combinational NZCV flags, plus a CPSR-style flag bank
// written per flag pair under FlagW.
module alu_nzcv #(
   parameter int unsigned WIDTH = 32
) (
   input logic      clk,
   input logic      rst_n,
   alu_nzcv_if.slave bus
);

   if (WIDTH < 2) begin : g_width_check
      $error("alu_nzcv: WIDTH must be at least 2");
   end

   localparam int unsigned Msb = WIDTH - 1;

   typedef enum logic [1:0] {
      OpAdd = 2'b00,
      OpSub = 2'b01,
      OpAnd = 2'b10,
      OpOrr = 2'b11
   } alu_op_e;

   alu_op_e          op;
   logic             is_sub;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] result;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic             arith_c;
   logic             arith_v;
   logic [3:0]       alu_flags;
   logic [3:0]       flags_d;
   logic [3:0]       flags_q;

   assign op     = alu_op_e'(bus.ALUControl);
   assign is_sub = bus.ALUControl[0];

   // One shared adder: SUB is a + ~b + 1, so carry out means "no borrow".
   always_comb begin
      b_op = is_sub ? ~bus.b : bus.b;
      sum  = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
   end

   // Overflow when the operands' effective signs agree but the result sign differs.
   always_comb begin
      arith_c = sum[WIDTH];
      arith_v = ~(bus.a[Msb] ^ bus.b[Msb] ^ is_sub) & (bus.a[Msb] ^ sum[Msb]);
   end

   always_comb begin
      result = '0;
      flag_c = 1'b0;
      flag_v = 1'b0;
      unique case (op)
         OpAdd: begin
            result = sum[WIDTH-1:0];
            flag_c = arith_c;
            flag_v = arith_v;
         end
         OpSub: begin
            result = sum[WIDTH-1:0];
            flag_c = arith_c;
            flag_v = arith_v;
         end
         OpAnd: result = bus.a & bus.b;
         OpOrr: result = bus.a | bus.b;
         default: result = '0;
      endcase
   end

   always_comb begin
      flag_n    = result[Msb];
      flag_z    = (result == '0);
      alu_flags = {flag_n, flag_z, flag_c, flag_v};
   end

   // Each FlagW bit owns one flag pair; disabled pairs keep their old value.
   always_comb begin
      flags_d = flags_q;
      if (bus.FlagW[1]) begin
         flags_d[3:2] = alu_flags[3:2];
      end
      if (bus.FlagW[0]) begin
         flags_d[1:0] = alu_flags[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign bus.Result   = result;
   assign bus.ALUFlags = alu_flags;
   assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_alu_nzcv.sv
// Directed-vector bench: each step queues its expected outputs; a negedge monitor
// pops and compares them against the DUT.
module tb_alu_nzcv;

   localparam int unsigned W = 32;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] AND = 2'b10;
   localparam logic [1:0] ORR = 2'b11;

   typedef struct {
      string        name;
      logic [W-1:0] res;
      logic [3:0]   alu;
      logic [3:0]   flg;
   } exp_t;

   logic clk;
   logic rst_n;

   alu_nzcv_if #(.WIDTH(W)) bus_if ();

   alu_nzcv #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   exp_t sb[$];
   int   n_checks;
   int   n_pass;

   // Flag-bank reference state and the controls that the next edge will commit.
   logic [3:0] model_flags;
   logic       pend_rst_n;
   logic [1:0] pend_flagw;
   logic [3:0] pend_alu;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input string what,
                        input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, what, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.name, "Result", bus_if.Result, e.res);
         check(e.name, "ALUFlags", {28'd0, bus_if.ALUFlags}, {28'd0, e.alu});
         check(e.name, "Flags", {28'd0, bus_if.Flags}, {28'd0, e.flg});
      end
   end

   task automatic step(input string name, input logic rst, input logic [1:0] ctl,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] flagw, input logic [W-1:0] exp_res,
                       input logic [3:0] exp_alu);
      exp_t e;
      @(posedge clk);
      if (!pend_rst_n) begin
         model_flags = 4'b0000;
      end else begin
         if (pend_flagw[1]) model_flags[3:2] = pend_alu[3:2];
         if (pend_flagw[0]) model_flags[1:0] = pend_alu[1:0];
      end
      #1;
      rst_n             = rst;
      bus_if.a          = a;
      bus_if.b          = b;
      bus_if.ALUControl = ctl;
      bus_if.FlagW      = flagw;
      if (!rst) model_flags = 4'b0000;
      e.name = name;
      e.res  = exp_res;
      e.alu  = exp_alu;
      e.flg  = model_flags;
      sb.push_back(e);
      pend_rst_n = rst;
      pend_flagw = flagw;
      pend_alu   = exp_alu;
   endtask

   initial begin
      n_checks          = 0;
      n_pass            = 0;
      model_flags       = 4'b0000;
      pend_rst_n        = 1'b0;
      pend_flagw        = 2'b00;
      pend_alu          = 4'b0000;
      rst_n             = 1'b0;
      bus_if.a          = '0;
      bus_if.b          = '0;
      bus_if.ALUControl = ADD;
      bus_if.FlagW      = 2'b00;

      step("reset",      1'b0, ADD, 32'h0000_0000, 32'h0000_0000, 2'b11, 32'h0000_0000, 4'b0100);
      step("rst_hold",   1'b0, ADD, 32'h0000_0007, 32'h0000_0001, 2'b11, 32'h0000_0008, 4'b0000);
      step("add_small",  1'b1, ADD, 32'h0000_0007, 32'h0000_0001, 2'b00, 32'h0000_0008, 4'b0000);
      step("add_wrap",   1'b1, ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b0110);
      step("and_one",    1'b1, AND, 32'h0000_0001, 32'h0000_0001, 2'b00, 32'h0000_0001, 4'b0000);
      step("orr_3_4",    1'b1, ORR, 32'h0000_0003, 32'h0000_0004, 2'b00, 32'h0000_0007, 4'b0000);
      step("and_zero",   1'b1, AND, 32'h0000_00F0, 32'h0000_000F, 2'b00, 32'h0000_0000, 4'b0100);
      step("sub_pos",    1'b1, SUB, 32'h0000_0010, 32'h0000_0005, 2'b00, 32'h0000_000B, 4'b0010);
      step("sub_borrow", 1'b1, SUB, 32'h0000_0001, 32'h0000_0002, 2'b00, 32'hFFFF_FFFF, 4'b1000);
      step("sub_eq",     1'b1, SUB, 32'h0000_0002, 32'h0000_0002, 2'b00, 32'h0000_0000, 4'b0110);
      step("sub_ovf",    1'b1, SUB, 32'h8000_0000, 32'h0000_0001, 2'b00, 32'h7FFF_FFFF, 4'b0011);
      step("add_ovf",    1'b1, ADD, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001);
      step("and_no_cv",  1'b1, AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF, 4'b1000);
      step("orr_neg",    1'b1, ORR, 32'h8000_0000, 32'h0000_0000, 2'b00, 32'h8000_0000, 4'b1000);
      step("wr_all",     1'b1, ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 32'h0000_0000, 4'b0110);
      step("after_wr",   1'b1, ADD, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001);
      step("async_rst",  1'b0, ORR, 32'h0000_0003, 32'h0000_0004, 2'b00, 32'h0000_0007, 4'b0000);
      step("wr_nz",      1'b1, SUB, 32'h0000_0002, 32'h0000_0002, 2'b10, 32'h0000_0000, 4'b0110);
      step("wr_cv",      1'b1, SUB, 32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b0011);
      step("hold",       1'b1, AND, 32'h0000_00F0, 32'h0000_000F, 2'b00, 32'h0000_0000, 4'b0100);
      step("hold2",      1'b1, ADD, 32'h0000_0007, 32'h0000_0001, 2'b00, 32'h0000_0008, 4'b0000);
      step("rst_prio",   1'b0, ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 32'h0000_0000, 4'b0110);
      step("rst_prio2",  1'b0, ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 32'h0000_0000, 4'b0110);
      step("rst_done",   1'b1, ORR, 32'h8000_0000, 32'h0000_0000, 2'b00, 32'h8000_0000, 4'b1000);
      step("post_rst",   1'b1, SUB, 32'h0000_0001, 32'h0000_0002, 2'b11, 32'hFFFF_FFFF, 4'b1000);
      step("post_wr",    1'b1, ADD, 32'h0000_0007, 32'h0000_0001, 2'b00, 32'h0000_0008, 4'b0000);

      for (int i = 0; i < 10 && sb.size() > 0; i++) begin
         @(posedge clk);
      end
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
